// File: rtl/arb_requester.sv
// arb_requester: requester end of the req/gnt handshake with a shared-resource arbiter.
//
// A one-cycle start with a non-zero burst length raises req. Once granted, one beat is
// streamed per granted cycle. Losing the grant mid-burst re-requests the remainder. After
// the last beat, req drops for one cycle so the arbiter can rotate. A request that waits
// TIMEOUT cycles without a grant is abandoned.
//
// Ports:
//   clk_i         system clock, rising edge
//   rst_i         asynchronous, active-high reset
//   start_i       one-cycle burst request from local logic
//   burst_len_i   beats requested, sampled only when start_i is accepted
//   gnt_i         grant from arbiter
//   req_o         request to arbiter
//   beat_valid_o  a beat is transferred this cycle
//   remain_o      beats outstanding, including the current beat
//   busy_o        block is not idle
//   done_o        one-cycle pulse on burst completion
//   timeout_o     one-cycle pulse on starvation abort
module arb_requester #(
  parameter int unsigned BURST_W = 4,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned TO_W    = 5
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [BURST_W-1:0] burst_len_i,
  input  logic               gnt_i,
  output logic               req_o,
  output logic               beat_valid_o,
  output logic [BURST_W-1:0] remain_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               timeout_o
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StOwn  = 2'd2,
    StRel  = 2'd3
  } state_e;

  localparam logic [TO_W-1:0]    WaitLast = TO_W'(TIMEOUT - 1);
  localparam logic [BURST_W-1:0] OneBeat  = BURST_W'(1);

  state_e             state_q, state_d;
  logic [BURST_W-1:0] remain_q, remain_d;
  logic [TO_W-1:0]    wait_q, wait_d;
  logic               done_q, done_d;
  logic               timeout_q, timeout_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      remain_q  <= '0;
      wait_q    <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      remain_q  <= remain_d;
      wait_q    <= wait_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    remain_d  = remain_q;
    wait_d    = wait_q;
    done_d    = 1'b0;
    timeout_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Zero-length starts are dropped without any visible effect.
        if (start_i && (burst_len_i != '0)) begin
          state_d  = StReq;
          remain_d = burst_len_i;
          wait_d   = '0;
        end
      end
      StReq: begin
        // A grant on the final wait cycle still wins over the abort.
        if (gnt_i) begin
          state_d = StOwn;
          wait_d  = '0;
        end else if (wait_q == WaitLast) begin
          state_d   = StIdle;
          remain_d  = '0;
          wait_d    = '0;
          timeout_d = 1'b1;
        end else begin
          wait_d = wait_q + TO_W'(1);
        end
      end
      StOwn: begin
        if (gnt_i) begin
          if (remain_q == OneBeat) begin
            state_d  = StRel;
            remain_d = '0;
          end else begin
            remain_d = remain_q - OneBeat;
          end
        end else begin
          // Pre-empted: keep the remainder and ask again.
          state_d = StReq;
          wait_d  = '0;
        end
      end
      StRel: begin
        state_d = StIdle;
        done_d  = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  assign req_o        = (state_q == StReq) || (state_q == StOwn);
  assign busy_o       = (state_q != StIdle);
  assign beat_valid_o = (state_q == StOwn) && gnt_i;
  assign remain_o     = remain_q;
  assign done_o       = done_q;
  assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_arb_requester.sv
// Self-checking bench for arb_requester: directed scenarios plus randomized traffic, all
// compared cycle by cycle against a transaction-level model of a single outstanding burst.
module tb_arb_requester;

  localparam int unsigned BurstW  = 4;
  localparam int unsigned Timeout = 16;
  localparam int unsigned ToW     = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [BurstW-1:0] burst_len;
  logic              gnt;
  logic              req, beat_valid, busy, done, timeout;
  logic [BurstW-1:0] remain;

  arb_requester #(
    .BURST_W(BurstW),
    .TIMEOUT(Timeout),
    .TO_W   (ToW)
  ) u_dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .burst_len_i (burst_len),
    .gnt_i       (gnt),
    .req_o       (req),
    .beat_valid_o(beat_valid),
    .remain_o    (remain),
    .busy_o      (busy),
    .done_o      (done),
    .timeout_o   (timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: one burst in flight, described by how many beats are left, whether
  // the grant is currently held, how long we have waited, and whether we are releasing.
  bit m_active, m_owned, m_release, m_done, m_to;
  int m_left, m_waited;

  function automatic void model_reset();
    m_active = 0; m_owned = 0; m_release = 0; m_done = 0; m_to = 0;
    m_left = 0; m_waited = 0;
  endfunction

  function automatic void model_step(input bit s, input int len, input bit g);
    bit nd = 0, nt = 0;
    if (!m_active) begin
      if (s && len != 0) begin
        m_active = 1; m_owned = 0; m_left = len; m_waited = 0;
      end
    end else if (m_release) begin
      m_active = 0; m_release = 0; nd = 1;
    end else if (m_owned) begin
      if (g) begin
        m_left--;
        if (m_left == 0) begin m_owned = 0; m_release = 1; end
      end else begin
        m_owned = 0; m_waited = 0;
      end
    end else if (g) begin
      m_owned = 1; m_waited = 0;
    end else begin
      m_waited++;
      if (m_waited == Timeout) begin m_active = 0; m_left = 0; nt = 1; end
    end
    m_done = nd;
    m_to   = nt;
  endfunction

  // Per-scenario observation counters.
  int beats_seen, dones_seen, tos_seen, req_cycles, max_remain;

  task automatic clear_obs();
    beats_seen = 0; dones_seen = 0; tos_seen = 0; req_cycles = 0; max_remain = 0;
  endtask

  task automatic compare_outputs(input bit g);
    check("req",        32'(req),        32'(m_active && !m_release));
    check("busy",       32'(busy),       32'(m_active));
    check("beat_valid", 32'(beat_valid), 32'(m_owned && g));
    check("remain",     32'(remain),     32'(m_left));
    check("done",       32'(done),       32'(m_done));
    check("timeout",    32'(timeout),    32'(m_to));
    beats_seen += int'(beat_valid);
    dones_seen += int'(done);
    tos_seen   += int'(timeout);
    req_cycles += int'(req);
    if (int'(remain) > max_remain) max_remain = int'(remain);
  endtask

  task automatic cycle(input bit s, input int len, input bit g);
    @(negedge clk);
    start = s; burst_len = BurstW'(len); gnt = g;
    #1 compare_outputs(g);
    @(posedge clk);
    model_step(s, len, g);
  endtask

  task automatic cycles(input int n, input bit g);
    for (int i = 0; i < n; i++) cycle(1'b0, 0, g);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; burst_len = '0; gnt = 1'b0;
    model_reset();
    clear_obs();
    #1;
    check("reset_req",  32'(req),    32'd0);
    check("reset_busy", 32'(busy),   32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Basic burst, grant held from the cycle after start.
    clear_obs();
    cycle(1'b1, 3, 1'b0);
    cycles(7, 1'b1);
    check("basic_beats", beats_seen, 3);
    check("basic_req",   req_cycles, 4);
    check("basic_done",  dones_seen, 1);

    // Pre-emption after two beats for three cycles.
    clear_obs();
    cycle(1'b1, 5, 1'b0);
    cycles(3, 1'b1);
    cycles(3, 1'b0);
    cycles(6, 1'b1);
    cycles(2, 1'b0);
    check("preempt_beats", beats_seen, 5);
    check("preempt_done",  dones_seen, 1);

    // Starvation: no grant at all.
    clear_obs();
    cycle(1'b1, 4, 1'b0);
    cycles(20, 1'b0);
    check("starve_req", req_cycles, Timeout);
    check("starve_to",  tos_seen,   1);
    check("starve_done", dones_seen, 0);

    // Grant on the last permitted wait cycle wins over the abort.
    clear_obs();
    cycle(1'b1, 4, 1'b0);
    cycles(Timeout - 1, 1'b0);
    cycles(7, 1'b1);
    check("late_gnt_to",    tos_seen,   0);
    check("late_gnt_done",  dones_seen, 1);
    check("late_gnt_beats", beats_seen, 4);

    // Zero-length start is ignored; start while busy is ignored.
    clear_obs();
    for (int i = 0; i < 3; i++) cycle(1'b1, 0, 1'b1);
    check("zero_len_req", req_cycles, 0);
    cycle(1'b1, 2, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 7, 1'b1);
    cycles(4, 1'b1);
    check("busy_start_beats", beats_seen, 2);
    check("busy_start_max",   max_remain, 2);

    // Back-to-back: second start on the done cycle.
    clear_obs();
    cycle(1'b1, 1, 1'b0);
    cycles(3, 1'b1);
    cycle(1'b1, 1, 1'b1);
    cycles(5, 1'b1);
    check("b2b_done",  dones_seen, 2);
    check("b2b_beats", beats_seen, 2);

    // Asynchronous reset in the middle of a granted burst.
    clear_obs();
    cycle(1'b1, 5, 1'b0);
    cycle(1'b0, 0, 1'b1);
    @(negedge clk);
    gnt = 1'b1; start = 1'b0;
    #1 compare_outputs(1'b1);
    #1 rst = 1'b1;
    #1;
    check("arst_req",    32'(req),        32'd0);
    check("arst_beat",   32'(beat_valid), 32'd0);
    check("arst_busy",   32'(busy),       32'd0);
    check("arst_remain", 32'(remain),     32'd0);
    check("arst_done",   32'(done),       32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    clear_obs();
    cycles(2, 1'b1);
    cycle(1'b1, 2, 1'b0);
    cycles(6, 1'b1);
    check("post_rst_done",  dones_seen, 1);
    check("post_rst_beats", beats_seen, 2);

    // Randomized traffic, alternating between generous and stingy arbiters.
    for (int blk = 0; blk < 20; blk++) begin
      int gnt_pct = (blk % 3 == 2) ? 5 : 30 + 15 * (blk % 4);
      for (int i = 0; i < 150; i++) begin
        bit s = ($urandom_range(99) < 25);
        int len = int'($urandom_range(15));
        bit g = ($urandom_range(99) < gnt_pct);
        cycle(s, len, g);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
